// File: rtl/fpu_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_pkg
// Constants and types shared by the floating-point adder and its operand
// sequencer.
// Number format: sign[31], exponent[30:25] (bias 31), mantissa[24:0] with an
// implicit leading 1.
// No ports; import with `import fpu_pkg::*;`.
// -----------------------------------------------------------------------------
package fpu_pkg;

    // Number of clock cycles the adder spends on one operation
    // (MOD_EXPO .. PARA_STATUS).
    localparam int FPU_PERIOD = 5;
    localparam int PH_W       = $clog2(FPU_PERIOD);

    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int BIAS   = 31;

    localparam int WORD_W = 1 + EXP_W + MANT_W;
    localparam int STAT_W = 4;
    localparam int TAG_W  = 4;

    // One-hot result status reported by the adder.
    typedef enum logic [STAT_W-1:0] {
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } fpu_status_e;

    // Advance an adder-phase counter, wrapping after the last phase.
    function automatic logic [PH_W-1:0] phase_next(input logic [PH_W-1:0] p);
        return (p == PH_W'(FPU_PERIOD - 1)) ? '0 : p + PH_W'(1);
    endfunction

endpackage

// File: rtl/fpu_operand_sequencer_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_operand_sequencer_if
// Bundles the operand stream, the adder-facing signals and the result strobe
// of fpu_operand_sequencer.
//   slave  : the sequencer itself
//   master : the environment (operand source, adder, result sink)
// Signals:
//   in_valid/in_ready/in_a/in_b  operand-pair stream into the sequencer
//   op_A_out/op_B_out            operands presented to the adder
//   fpu_data_in/fpu_status_in    adder result and status
//   res_valid/res_data/res_status captured result strobe
// Optional feature macro: FPU_SEQ_TAG_EN adds in_tag and res_tag.
// -----------------------------------------------------------------------------
interface fpu_operand_sequencer_if;
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic [WORD_W-1:0] op_A_out;
    logic [WORD_W-1:0] op_B_out;
    logic [WORD_W-1:0] fpu_data_in;
    logic [STAT_W-1:0] fpu_status_in;
    logic              res_valid;
    logic [WORD_W-1:0] res_data;
    logic [STAT_W-1:0] res_status;
`ifdef FPU_SEQ_TAG_EN
    logic [TAG_W-1:0]  in_tag;
    logic [TAG_W-1:0]  res_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, fpu_data_in, fpu_status_in,
        output in_ready, op_A_out, op_B_out, res_valid, res_data, res_status, res_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, fpu_data_in, fpu_status_in,
        input  in_ready, op_A_out, op_B_out, res_valid, res_data, res_status, res_tag
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, fpu_data_in, fpu_status_in,
        output in_ready, op_A_out, op_B_out, res_valid, res_data, res_status
    );

    modport master (
        output in_valid, in_a, in_b, fpu_data_in, fpu_status_in,
        input  in_ready, op_A_out, op_B_out, res_valid, res_data, res_status
    );
`endif

endinterface

// File: rtl/fpu_seq_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_seq_fifo
// Synchronous first-word-fall-through FIFO holding operand entries for the
// sequencer. The head entry is always visible on rdata while not empty.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write an entry (ignored while full)
//   pop           drop the head entry (ignored while empty)
//   rdata         current head entry
//   full, empty   occupancy flags
//   count         number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fpu_seq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpu_operand_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_operand_sequencer
// Feeds operand pairs to the 5-state floating-point adder. Pairs arrive on a
// valid/ready stream, wait in a small FIFO, and are presented on
// op_A_out/op_B_out for one full adder period starting at MOD_EXPO. One period
// later the adder's result is captured and emitted as a single-cycle
// res_valid strobe, in issue order.
// Ports:
//   clock100KHz  single clock
//   reset        synchronous active-high reset; the adder receives ~reset so
//                both leave reset on the same edge
//   bus          fpu_operand_sequencer_if.slave (stream, adder and result
//                signals; see the interface header)
// Optional feature macro: FPU_SEQ_TAG_EN carries a 4-bit tag from in_tag to
// res_tag alongside each pair.
// -----------------------------------------------------------------------------
module fpu_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    fpu_operand_sequencer_if.slave   bus
);
    import fpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FPU_SEQ_TAG_EN
    localparam int ENTRY_W = 2 * WORD_W + TAG_W;
`else
    localparam int ENTRY_W = 2 * WORD_W;
`endif

    // phase_q == 0 while the adder sits in MOD_EXPO, FPU_PERIOD-1 in PARA_STATUS.
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [WORD_W-1:0] op_a_q, op_a_d;
    logic [WORD_W-1:0] op_b_q, op_b_d;
    logic              issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic              res_valid_q, res_valid_d;
    logic [WORD_W-1:0] res_data_q, res_data_d;
    logic [STAT_W-1:0] res_status_q, res_status_d;
`ifdef FPU_SEQ_TAG_EN
    logic [TAG_W-1:0]  issued_tag_q, issued_tag_d;
    logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               at_boundary;
    logic               capture;

    // ---- stage: operand queue -------------------------------------------
`ifdef FPU_SEQ_TAG_EN
    assign fifo_wdata = {bus.in_tag, bus.in_a, bus.in_b};
`else
    assign fifo_wdata = {bus.in_a, bus.in_b};
`endif

    assign bus.in_ready = (fifo_count < CNT_W'(DEPTH));
    assign fifo_push    = bus.in_valid && !fifo_full;

    // The head is popped on the same edge that starts the adder's MOD_EXPO, so
    // an entry written on that edge waits for the following boundary.
    assign at_boundary = (phase_q == PH_W'(FPU_PERIOD - 1));
    assign fifo_pop    = at_boundary && !fifo_empty;

    fpu_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock100KHz),
        .rst   (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---- stage: issue and capture ---------------------------------------
    // The adder's data_out for an operation issued at edge E becomes valid at
    // E+FPU_PERIOD; it is sampled on the edge that ends phase 0 of the next
    // period, which is why inflight is issued delayed by one full period.
    assign capture = (phase_q == '0) && inflight_q;

    always_comb begin
        phase_d      = phase_next(phase_q);
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        issued_d     = issued_q;
        inflight_d   = inflight_q;
        res_valid_d  = capture;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
`ifdef FPU_SEQ_TAG_EN
        issued_tag_d   = issued_tag_q;
        inflight_tag_d = inflight_tag_q;
        res_tag_d      = res_tag_q;
`endif

        if (at_boundary) begin
            issued_d   = fifo_pop;
            inflight_d = issued_q;
`ifdef FPU_SEQ_TAG_EN
            inflight_tag_d = issued_tag_q;
`endif
        end

        // With nothing queued the operand registers keep their last value.
        if (fifo_pop) begin
            op_a_d = fifo_rdata[2*WORD_W-1:WORD_W];
            op_b_d = fifo_rdata[WORD_W-1:0];
`ifdef FPU_SEQ_TAG_EN
            issued_tag_d = fifo_rdata[ENTRY_W-1 -: TAG_W];
`endif
        end

        if (capture) begin
            res_data_d   = bus.fpu_data_in;
            res_status_d = bus.fpu_status_in;
`ifdef FPU_SEQ_TAG_EN
            res_tag_d    = inflight_tag_q;
`endif
        end
    end

    // ---- stage: registered outputs --------------------------------------
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            phase_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            issued_q     <= 1'b0;
            inflight_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
`ifdef FPU_SEQ_TAG_EN
            issued_tag_q   <= '0;
            inflight_tag_q <= '0;
            res_tag_q      <= '0;
`endif
        end else begin
            phase_q      <= phase_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
`ifdef FPU_SEQ_TAG_EN
            issued_tag_q   <= issued_tag_d;
            inflight_tag_q <= inflight_tag_d;
            res_tag_q      <= res_tag_d;
`endif
        end
    end

    assign bus.op_A_out   = op_a_q;
    assign bus.op_B_out   = op_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_status = res_status_q;
`ifdef FPU_SEQ_TAG_EN
    assign bus.res_tag    = res_tag_q;
`endif

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fpu_operand_sequencer
// Drives fpu_operand_sequencer with directed and random operand traffic. A
// stand-in for the 5-state adder (reset by ~reset) computes a simplified
// float sum from the operands it holds for a period. A queue-based model of
// the sequencer predicts every output each cycle.
// Optional feature macro: FPU_SEQ_TAG_EN enables the tag checks.
// -----------------------------------------------------------------------------
module tb_fpu_operand_sequencer;
    import fpu_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_operand_sequencer_if bus ();

    fpu_operand_sequencer #(.DEPTH(DEPTH)) dut (
        .clock100KHz (clk),
        .reset       (reset),
        .bus         (bus)
    );

    // Simplified magnitude add: align, add, renormalise once, truncate.
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, sum;
        int          ex, ey, d, e;
        logic        lost;
        logic [3:0]  st;
        logic [31:0] r;
        if (a[30:25] >= b[30:25]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = int'(x[30:25]);
        ey = int'(y[30:25]);
        d  = ex - ey;
        mx = {2'b01, x[24:0]};
        my = {2'b01, y[24:0]};
        lost = 1'b0;
        if (d >= 27) begin
            lost = 1'b1;
            my   = '0;
        end else begin
            for (int i = 0; i < d; i++) lost = lost | my[i];
            my = my >> d;
        end
        sum = mx + my;
        e   = ex;
        if (sum[26]) begin
            lost = lost | sum[0];
            sum  = sum >> 1;
            e    = e + 1;
        end
        if (e > 63) begin
            st = ST_OVERFLOW;
            r  = {x[31], 6'h3f, 25'h0};
        end else begin
            st = lost ? ST_INEXACT : ST_EXACT;
            r  = {x[31], e[5:0], sum[24:0]};
        end
        return {st, r};
    endfunction

    // Adder stand-in: result appears on the edge that leaves its last state.
    logic        adder_rst_n;
    int unsigned add_state;
    logic [31:0] add_data;
    logic [3:0]  add_stat;
    assign adder_rst_n = ~reset;
    always @(posedge clk) begin
        if (!adder_rst_n) begin
            add_state <= 0;
            add_data  <= '0;
            add_stat  <= '0;
        end else if (add_state == FPU_PERIOD - 1) begin
            add_state             <= 0;
            {add_stat, add_data}  <= ref_add(bus.op_A_out, bus.op_B_out);
        end else begin
            add_state <= add_state + 1;
        end
    end
    assign bus.fpu_data_in   = add_data;
    assign bus.fpu_status_in = add_stat;

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] tag; } pair_t;
    typedef struct { int due; logic [35:0] r; logic [3:0] tag; } res_t;
    pair_t       mq[$];
    res_t        pend[$];
    int          ph = 0;
    int          ecnt = 0;
    logic [31:0] m_opa = '0, m_opb = '0, m_rd = '0;
    logic [3:0]  m_rs = '0, m_rt = '0;
    logic        m_vld = 1'b0;
    bit          model_live = 0;

    initial begin
        pair_t p;
        res_t  rr;
        bit    acc;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                pend.delete();
                ph = 0; ecnt = 0;
                m_opa = '0; m_opb = '0; m_rd = '0; m_rs = '0; m_rt = '0; m_vld = 1'b0;
            end else begin
                acc   = bus.in_valid && (mq.size() < DEPTH);
                m_vld = 1'b0;
                if (pend.size() > 0 && pend[0].due == ecnt) begin
                    rr    = pend.pop_front();
                    m_vld = 1'b1;
                    m_rd  = rr.r[31:0];
                    m_rs  = rr.r[35:32];
                    m_rt  = rr.tag;
                end
                if (ph == FPU_PERIOD - 1 && mq.size() > 0) begin
                    p      = mq.pop_front();
                    m_opa  = p.a;
                    m_opb  = p.b;
                    rr.due = ecnt + FPU_PERIOD + 1;
                    rr.r   = ref_add(p.a, p.b);
                    rr.tag = p.tag;
                    pend.push_back(rr);
                end
                if (acc) begin
                    p.a = bus.in_a;
                    p.b = bus.in_b;
`ifdef FPU_SEQ_TAG_EN
                    p.tag = bus.in_tag;
`else
                    p.tag = 4'h0;
`endif
                    mq.push_back(p);
                end
                ph   = (ph + 1) % FPU_PERIOD;
                ecnt = ecnt + 1;
            end
            model_live = 1;
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("in_ready",   32'(bus.in_ready),   32'(mq.size() < DEPTH));
                chk("op_A_out",   bus.op_A_out,        m_opa);
                chk("op_B_out",   bus.op_B_out,        m_opb);
                chk("res_valid",  32'(bus.res_valid),  32'(m_vld));
                chk("res_data",   bus.res_data,        m_rd);
                chk("res_status", 32'(bus.res_status), 32'(m_rs));
`ifdef FPU_SEQ_TAG_EN
                chk("res_tag",    32'(bus.res_tag),    32'(m_rt));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FPU_PERIOD; i++) begin
            @(posedge clk);
            #1;
            if (ph == p) return;
        end
        timeout("wait_phase");
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
`ifdef FPU_SEQ_TAG_EN
        bus.in_tag   = tag;
`else
        if (tag != 4'h0) bus.in_a = a;
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int          first, pulses, lows, prob;
        logic [31:0] rd;
        logic [3:0]  rs;
        int          times[$];
        logic [3:0]  tags[$];

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
`ifdef FPU_SEQ_TAG_EN
        bus.in_tag   = '0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values on release.
        @(negedge clk);
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_op_a",       bus.op_A_out,        32'd0);
        chk("rst_res_valid",  32'(bus.res_valid),  32'd0);
        chk("rst_res_status", 32'(bus.res_status), 32'd0);

        // Single pair 1.0 + 1.0 pushed at phase 2.
        wait_phase(2);
        push_one(32'h3E00_0000, 32'h3E00_0000, 4'h0);
        first = 0; pulses = 0; rd = '0; rs = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    rd    = bus.res_data;
                    rs    = bus.res_status;
                end
            end
        end
        chk("single_latency", 32'(first),  32'd9);
        chk("single_pulses",  32'(pulses), 32'd1);
        chk("single_data",    rd,          32'h4000_0000);
        chk("single_status",  32'(rs),     32'h1);

        // Idle: operands hold, nothing emitted.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
        end
        chk("idle_pulses", 32'(pulses),  32'd0);
        chk("idle_op_a",   bus.op_A_out, 32'h3E00_0000);
        chk("idle_op_b",   bus.op_B_out, 32'h3E00_0000);

        // Burst of four pairs starting at phase 1.
        wait_phase(1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_a = 32'h3E00_0000 + 32'(i << 22);
            bus.in_b = 32'h3C00_0000 + 32'(i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        times.delete();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.res_valid) times.push_back(i);
        end
        chk("burst_pulses", 32'(times.size()), 32'd4);
        if (times.size() >= 4) begin
            chk("burst_first", 32'(times[0]), 32'd7);
            for (int i = 1; i < 4; i++) chk("burst_gap", 32'(times[i] - times[i-1]), 32'd5);
        end

        // Hold in_valid to fill the FIFO.
        lows = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_a = $urandom;
            bus.in_b = $urandom;
            @(negedge clk);
            if (!bus.in_ready) lows++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("fill_ready_low", 32'(lows > 0), 32'd1);

        // Reset at phase 3 with work in flight and queued.
        wait_phase(3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_op_a",     bus.op_A_out,      32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
        end
        chk("midrst_pulses", 32'(pulses), 32'd0);

`ifdef FPU_SEQ_TAG_EN
        // Tags travel with their pairs.
        wait_phase(0);
        bus.in_valid = 1'b1;
        bus.in_a = 32'h3E00_0000; bus.in_b = 32'h3E00_0000; bus.in_tag = 4'hA;
        @(posedge clk);
        #1;
        bus.in_a = 32'h4000_0000; bus.in_b = 32'h3E00_0000; bus.in_tag = 4'h5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tags.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid) tags.push_back(bus.res_tag);
        end
        chk("tag_count", 32'(tags.size()), 32'd2);
        if (tags.size() >= 2) begin
            chk("tag_first",  32'(tags[0]), 32'hA);
            chk("tag_second", 32'(tags[1]), 32'h5);
        end
`else
        tags.delete();
`endif

        // Random traffic with occasional resets.
        prob = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) begin
                case ((c / 250) % 3)
                    0:       prob = 15;
                    1:       prob = 50;
                    default: prob = 95;
                endcase
            end
            bus.in_valid = ($urandom_range(0, 99) < prob);
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
`ifdef FPU_SEQ_TAG_EN
            bus.in_tag   = 4'($urandom);
`endif
            reset = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #1;
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
